lvt_ram_mrnw: RTL and testbench

LVT_RAM_MRNW -- requirements
Module: lvt_ram_mrnw

---
 rtl/lvt_ram_mrnw.sv | 186 ++++++++++++++++++
 tb/tb_lvt_ram_mrnw.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvt_ram_mrnw.sv
// -----------------------------------------------------------------------------
// lvt_ram_mrnw
//
// Multi-write / multi-read RAM built from one bank per write port plus a
// live-value table (LVT). Each write port owns a bank. The LVT records, per
// address, which bank holds the most recent value. Reads look up the LVT and
// then select that bank.
//
// After reset or a clr request, an INIT sweep zeroes LVT and bank 0, one
// address per cycle. Because every LVT entry then points at bank 0, the other
// banks never need clearing.
//
// Parameters
//   DW     : data width in bits
//   AW     : address width; depth is 2**AW
//   NW     : number of write ports (1..8)
//   NR     : number of read ports (1..4)
//   BYPASS : 1 forwards same-edge winning write data to the read outputs
//
// Ports
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   clr        : synchronous request to re-run the initialisation sweep
//   ready      : high while writes are accepted (RUN state)
//   w_enb      : per-port write enable                  [NW]
//   w_addr     : write addresses, port i at [i*AW +: AW]
//   w_din      : write data,      port i at [i*DW +: DW]
//   r_addr     : read addresses,  port j at [j*AW +: AW]
//   r_dout     : registered read data, port j at [j*DW +: DW]
//   w_conflict : registered flag, set after an edge where enabled ports collided
// -----------------------------------------------------------------------------
module lvt_ram_mrnw #(
    parameter int DW     = 32,
    parameter int AW     = 10,
    parameter int NW     = 4,
    parameter int NR     = 2,
    parameter int BYPASS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    output logic             ready,
    input  logic [NW-1:0]    w_enb,
    input  logic [NW*AW-1:0] w_addr,
    input  logic [NW*DW-1:0] w_din,
    input  logic [NR*AW-1:0] r_addr,
    output logic [NR*DW-1:0] r_dout,
    output logic             w_conflict
);

    localparam int DEPTH = 2 ** AW;
    localparam int LW    = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_conflict;

    logic [DW-1:0] r_bank [NW][DEPTH];
    logic [LW-1:0] r_lvt  [DEPTH];

    // Unpacked views of the flattened port buses.
    logic [AW-1:0] w_wa [NW];
    logic [DW-1:0] w_wd [NW];
    logic [AW-1:0] w_ra [NR];
    logic [DW-1:0] w_rd [NR];

    for (genvar gi = 0; gi < NW; gi++) begin : g_wport
        assign w_wa[gi] = w_addr[gi*AW +: AW];
        assign w_wd[gi] = w_din[gi*DW +: DW];
    end

    for (genvar gj = 0; gj < NR; gj++) begin : g_rport
        assign w_ra[gj] = r_addr[gj*AW +: AW];
    end

    logic          w_run;
    logic          w_accept;
    logic          w_sweep;
    logic [NW-1:0] w_win;
    logic          w_collide;

    assign w_run    = (r_state == ST_RUN);
    // A clr edge discards any writes presented with it.
    assign w_accept = w_run && !clr;
    // A clr in INIT restarts the sweep, so that edge writes nothing.
    assign w_sweep  = (r_state == ST_INIT) && !clr;
    assign ready    = w_run;

    // Winner selection: a port writes only if no lower-index enabled port
    // targets the same address on this edge.
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no latch can be inferred.
    always_comb begin
        for (int i = 0; i < NW; i++) begin
            w_win[i] = w_accept && w_enb[i];
            for (int k = 0; k < i; k++) begin
                if (w_enb[k] && (w_wa[k] == w_wa[i])) begin
                    w_win[i] = 1'b0;
                end
            end
        end
    end

    // An enabled port that lost arbitration means a same-address collision.
    assign w_collide = w_accept && |(w_enb & ~w_win);

    // Next-state logic for the INIT/RUN sequencer and the sweep counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (clr) begin
            w_state_nxt = ST_INIT;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_INIT) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (&r_cnt) begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: storage arrays have no reset; the INIT sweep clears the LVT and
    // bank 0, and that alone makes every address read as zero.
    always_ff @(posedge clk) begin
        if (w_sweep) begin
            r_lvt[r_cnt]     <= '0;
            r_bank[0][r_cnt] <= '0;
        end
        // Winning addresses are distinct, so these writes never overlap.
        for (int i = 0; i < NW; i++) begin
            if (w_win[i]) begin
                r_bank[i][w_wa[i]] <= w_wd[i];
                r_lvt[w_wa[i]]     <= LW'(i);
            end
        end
    end

    // Read path: LVT lookup selects the live bank, optionally overridden by
    // a winning write to the same address on this edge.
    always_comb begin
        for (int j = 0; j < NR; j++) begin
            w_rd[j] = r_bank[r_lvt[w_ra[j]]][w_ra[j]];
            if (BYPASS != 0) begin
                for (int i = 0; i < NW; i++) begin
                    if (w_win[i] && (w_wa[i] == w_ra[j])) begin
                        w_rd[j] = w_wd[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout     <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_conflict <= w_collide;
            for (int j = 0; j < NR; j++) begin
                r_dout[j*DW +: DW] <= (r_state == ST_INIT) ? '0 : w_rd[j];
            end
        end
    end

    assign w_conflict = r_conflict;

endmodule

// File: tb/tb_lvt_ram_mrnw.sv
// -----------------------------------------------------------------------------
// tb_lvt_ram_mrnw
//
// Self-checking bench for lvt_ram_mrnw. Two instances share all inputs:
// dut0 uses BYPASS=0 and dut1 uses BYPASS=1.
//
// The reference model treats the RAM as one flat array of the latest value per
// address. A "ready" flag and a remaining-sweep-cycle count stand in for the
// INIT/RUN sequencing.
// -----------------------------------------------------------------------------
module tb_lvt_ram_mrnw;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int NW    = 4;
    localparam int NR    = 2;
    localparam int DEPTH = 2 ** AW;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr = 1'b0;
    logic [NW-1:0]    w_enb = '0;
    logic [NW*AW-1:0] w_addr = '0;
    logic [NW*DW-1:0] w_din = '0;
    logic [NR*AW-1:0] r_addr = '0;

    logic             ready0, ready1;
    logic             conf0, conf1;
    logic [NR*DW-1:0] r_dout0, r_dout1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model state.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_ready;
    int            m_left;

    always #5 clk = ~clk;

    lvt_ram_mrnw #(.DW(DW), .AW(AW), .NW(NW), .NR(NR), .BYPASS(0)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready0),
        .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
        .r_addr(r_addr), .r_dout(r_dout0), .w_conflict(conf0)
    );

    lvt_ram_mrnw #(.DW(DW), .AW(AW), .NW(NW), .NR(NR), .BYPASS(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .ready(ready1),
        .w_enb(w_enb), .w_addr(w_addr), .w_din(w_din),
        .r_addr(r_addr), .r_dout(r_dout1), .w_conflict(conf1)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
    endtask

    task automatic idle();
        clr   = 1'b0;
        w_enb = '0;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_enb[i]           = 1'b1;
        w_addr[i*AW +: AW] = a;
        w_din[i*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int j, input logic [AW-1:0] a);
        r_addr[j*AW +: AW] = a;
    endtask

    task automatic rand_inputs(input int amask);
        for (int i = 0; i < NW; i++) begin
            w_enb[i]           = 1'($urandom_range(0, 1));
            w_addr[i*AW +: AW] = AW'($urandom & amask);
            w_din[i*DW +: DW]  = $urandom;
        end
        for (int j = 0; j < NR; j++) r_addr[j*AW +: AW] = AW'($urandom & amask);
    endtask

    task automatic check_zero_outputs(input string phase);
        check({phase, "_ready0"}, DW'(ready0), '0);
        check({phase, "_ready1"}, DW'(ready1), '0);
        check({phase, "_conf0"}, DW'(conf0), '0);
        check({phase, "_conf1"}, DW'(conf1), '0);
        check({phase, "_dout0"}, r_dout0[DW-1:0] | r_dout0[2*DW-1:DW], '0);
        check({phase, "_dout1"}, r_dout1[DW-1:0] | r_dout1[2*DW-1:DW], '0);
    endtask

    // Asserts rst asynchronously between edges, holds it, then releases it.
    task automatic apply_reset(input int cycles);
        rst = 1'b1;
        #1;
        check_zero_outputs("rst_async");
        repeat (cycles) @(posedge clk);
        #1;
        check_zero_outputs("rst_hold");
        rst     = 1'b0;
        m_ready = 1'b0;
        m_left  = DEPTH;
        clear_model();
    endtask

    // Computes the expected post-edge outputs from the current inputs,
    // advances one clock edge, and compares all outputs of both instances.
    task automatic tick();
        logic [DW-1:0] e0 [NR];
        logic [DW-1:0] e1 [NR];
        logic [AW-1:0] wa_q [NW];
        logic [DW-1:0] wd_q [NW];
        logic [AW-1:0] a;
        logic          e_conf;
        bit            claimed [int];
        int            n;
        e_conf = 1'b0;
        n      = 0;
        for (int j = 0; j < NR; j++) begin
            e0[j] = '0;
            e1[j] = '0;
        end
        if (m_ready) begin
            for (int j = 0; j < NR; j++) begin
                e0[j] = m_mem[r_addr[j*AW +: AW]];
                e1[j] = e0[j];
            end
            if (clr) begin
                m_ready = 1'b0;
                m_left  = DEPTH;
                clear_model();
            end else begin
                for (int i = 0; i < NW; i++) begin
                    if (w_enb[i]) begin
                        a = w_addr[i*AW +: AW];
                        if (claimed.exists(int'(a))) begin
                            e_conf = 1'b1;
                        end else begin
                            claimed[int'(a)] = 1'b1;
                            wa_q[n] = a;
                            wd_q[n] = w_din[i*DW +: DW];
                            n++;
                        end
                    end
                end
                for (int j = 0; j < NR; j++)
                    for (int k = 0; k < n; k++)
                        if (wa_q[k] == r_addr[j*AW +: AW]) e1[j] = wd_q[k];
                for (int k = 0; k < n; k++) m_mem[wa_q[k]] = wd_q[k];
            end
        end else begin
            if (clr) begin
                m_left = DEPTH;
            end else begin
                m_left--;
                if (m_left == 0) m_ready = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check("ready0", DW'(ready0), DW'(m_ready));
        check("ready1", DW'(ready1), DW'(m_ready));
        check("conf0", DW'(conf0), DW'(e_conf));
        check("conf1", DW'(conf1), DW'(e_conf));
        for (int j = 0; j < NR; j++) begin
            check(j == 0 ? "dout0_p0" : "dout0_p1", r_dout0[j*DW +: DW], e0[j]);
            check(j == 0 ? "dout1_p0" : "dout1_p1", r_dout1[j*DW +: DW], e1[j]);
        end
    endtask

    // Ticks with random (ignored) writes until ready rises; returns the
    // number of edges taken, bounded so a stuck sequencer cannot hang.
    task automatic sweep_until_ready(output int edges);
        edges = -1;
        for (int c = 1; c <= DEPTH + 64; c++) begin
            rand_inputs(DEPTH - 1);
            tick();
            if (ready0 === 1'b1) begin
                edges = c;
                break;
            end
        end
        idle();
    endtask

    task automatic read_all_zero_sweep(input int naddr);
        idle();
        for (int a = 0; a < naddr; a += NR) begin
            for (int j = 0; j < NR; j++) set_rd(j, AW'(a + j));
            tick();
        end
    endtask

    int edges;

    initial begin
        m_ready = 1'b0;
        m_left  = DEPTH;
        clear_model();
        #2;

        // Power-on reset, then the full sweep; writes during INIT are ignored.
        apply_reset(3);
        sweep_until_ready(edges);
        check("init_latency", DW'(edges), DW'(DEPTH));
        read_all_zero_sweep(DEPTH);

        // Later write from a different port takes over the address.
        idle();
        set_wr(2, 10'd5, 32'hAAAA0002);
        tick();
        idle();
        set_wr(0, 10'd5, 32'h11110000);
        tick();
        idle();
        set_rd(0, 10'd5);
        set_rd(1, 10'd5);
        tick();
        check("lvt_rd_p0", r_dout0[0 +: DW], 32'h11110000);
        check("lvt_rd_p1", r_dout0[DW +: DW], 32'h11110000);

        // Same-address collision: lowest port wins, flag for one cycle.
        set_wr(1, 10'd9, 32'h000000B1);
        set_wr(3, 10'd9, 32'h000000B3);
        tick();
        check("conflict_set", DW'(conf0), 32'd1);
        idle();
        set_rd(0, 10'd9);
        tick();
        check("conflict_clr", DW'(conf0), 32'd0);
        check("conflict_win", r_dout0[0 +: DW], 32'h000000B1);

        // Read during write to the same address: old value vs forwarded.
        set_wr(0, 10'd7, 32'h00000005);
        tick();
        idle();
        set_wr(3, 10'd7, 32'h00000077);
        set_rd(0, 10'd7);
        set_rd(1, 10'd7);
        tick();
        check("bypass0_old", r_dout0[0 +: DW], 32'h00000005);
        check("bypass1_new", r_dout1[0 +: DW], 32'h00000077);

        // Random traffic on a small address window to provoke collisions.
        for (int r = 0; r < 400; r++) begin
            rand_inputs(15);
            tick();
        end

        // Fill 0..15, then clr with a write presented on the same edge.
        idle();
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NW; i++) set_wr(i, AW'(b * NW + i), 32'hC0DE0000 | (b * NW + i));
            tick();
        end
        idle();
        clr = 1'b1;
        set_wr(0, 10'd3, 32'hDEADBEEF);
        tick();
        check("clr_ready_drop", DW'(ready0), 32'd0);
        idle();
        sweep_until_ready(edges);
        check("clr_latency", DW'(edges), DW'(DEPTH));
        read_all_zero_sweep(16);

        // Reset in the middle of a sweep restarts it in full.
        apply_reset(2);
        for (int c = 0; c < 500; c++) begin
            rand_inputs(DEPTH - 1);
            tick();
        end
        idle();
        apply_reset(2);
        sweep_until_ready(edges);
        check("rst_mid_latency", DW'(edges), DW'(DEPTH));
        read_all_zero_sweep(DEPTH);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
